// File: rtl/arch_defs_pkg.sv
// Architecture-wide constants shared by the datapath blocks.
package arch_defs_pkg;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/uart_pkg.sv
// Shared UART type definitions.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output (dout shows the oldest entry).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset: the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back to back while data is queued.
module uart_tx_fifo
  import arch_defs_pkg::*;
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_write,
  output logic                  tx_full,
  output logic                  tx_busy,
  output logic                  tx_overflow,
  output logic                  frame_done,
  output logic                  uart_tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  uart_tx_state_t        state;
  uart_tx_state_t        state_next;
  logic [CNT_W-1:0]      cycle_cnt;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  bit_end;

  assign bit_end   = (cycle_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign fifo_push = tx_write && !fifo_full;
  assign tx_full   = fifo_full;
  assign tx_busy   = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (tx_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = START;
        end
      end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_cnt == 3'(DATA_BITS - 1)) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      uart_tx     <= 1'b1;
      frame_done  <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && bit_end;
      if (tx_write && fifo_full) tx_overflow <= 1'b1;

      if (state == IDLE || bit_end) cycle_cnt <= '0;
      else                          cycle_cnt <= cycle_cnt + CNT_W'(1);

      if (fifo_pop)                       shift_reg <= fifo_dout;
      else if (state == DATA && bit_end)  shift_reg <= shift_reg >> 1;

      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;

      case (state)
        START:   uart_tx <= 1'b0;
        DATA:    uart_tx <= shift_reg[0];
        default: uart_tx <= 1'b1;
      endcase
    end
  end
endmodule
